// File: rtl/mem_sram_bridge_if.sv
// SRAM-like data bus seen by the MEM-stage bridge: registered request fields
// plus the addr_ok/data_ok handshake and returned read data.
interface mem_sram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              req;
  logic              wr;
  logic [SEL_W-1:0]  select;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, select, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, select, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_sram_bridge.sv
// Bridges the MEM stage's level-style access onto the SRAM-like bus, tracking
// in-flight transactions so responses of flushed accesses are silently dropped.
module mem_sram_bridge #(
  parameter  int ADDR_W          = 32,
  parameter  int DATA_W          = 32,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int SEL_W           = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              enable,
  input  logic              we,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  output logic              mem_write_finish,
  output logic              mem_read_finish,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_stall_o,
  mem_sram_bridge_if.master bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state, state_next;
  logic              doomed, doomed_next;
  logic [CNT_W-1:0]  inflight, discard;
  logic [CNT_W-1:0]  inflight_next, discard_next, inflight_avail;
  logic              wr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              latch_en, new_discard, finish;
  logic              resp_valid, discarding, own_resp, accept;

  // A data_ok with nothing in flight is a protocol violation and is ignored.
  assign resp_valid     = bus.data_ok && (inflight != '0);
  assign discarding     = resp_valid && (discard != '0);
  assign own_resp       = (state == RESP) && resp_valid && (discard == '0);
  assign accept         = (state == REQ) && bus.addr_ok;
  assign inflight_avail = inflight - CNT_W'(resp_valid);

  always_comb begin
    state_next  = state;
    doomed_next = doomed;
    latch_en    = 1'b0;
    new_discard = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        // A response returning this cycle frees its slot for a new request.
        if (enable && !flush && (inflight_avail < MAX_CNT)) begin
          latch_en   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.addr_ok) begin
          doomed_next = 1'b0;
          if (doomed || flush) begin
            new_discard = 1'b1;
            state_next  = IDLE;
          end else begin
            state_next = RESP;
          end
        end else if (flush) begin
          doomed_next = 1'b1;
        end
      end
      RESP: begin
        if (own_resp) begin
          finish     = !flush;
          state_next = IDLE;
        end else if (flush) begin
          new_discard = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    inflight_next = inflight + CNT_W'(accept) - CNT_W'(resp_valid);
    discard_next  = discard + CNT_W'(new_discard) - CNT_W'(discarding);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      doomed   <= 1'b0;
      inflight <= '0;
      discard  <= '0;
      wr_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_next;
      doomed   <= doomed_next;
      inflight <= inflight_next;
      discard  <= discard_next;
      if (latch_en) begin
        wr_q    <= we;
        sel_q   <= mem_sel_i;
        addr_q  <= mem_addr_i;
        wdata_q <= mem_data_i;
      end
    end
  end

  assign bus.req    = (state == REQ);
  assign bus.wr     = wr_q;
  assign bus.select = sel_q;
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;

  assign mem_read_finish  = finish && !wr_q;
  assign mem_write_finish = finish && wr_q;
  assign mem_data_o       = bus.rdata;
  assign mem_stall_o      = enable && !(mem_read_finish || mem_write_finish);

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Directed bench for mem_sram_bridge: a vector table on a MAX_OUTSTANDING=2
// instance plus hand-written sequences for the single-slot and reset cases.
module tb_mem_sram_bridge;

  logic clk;
  logic rst;

  logic        flush_a, en_a, we_a;
  logic [31:0] addr_a, wdata_a, data_o_a;
  logic [3:0]  sel_a;
  logic        rfin_a, wfin_a, stall_a;

  logic        flush_b, en_b, we_b;
  logic [31:0] addr_b, wdata_b, data_o_b;
  logic [3:0]  sel_b;
  logic        rfin_b, wfin_b, stall_b;

  int checks   = 0;
  int failures = 0;

  mem_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_sram_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .enable(en_a), .we(we_a),
    .mem_addr_i(addr_a), .mem_data_i(wdata_a), .mem_sel_i(sel_a),
    .mem_write_finish(wfin_a), .mem_read_finish(rfin_a),
    .mem_data_o(data_o_a), .mem_stall_o(stall_a), .bus(bus_a)
  );

  mem_sram_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .enable(en_b), .we(we_b),
    .mem_addr_i(addr_b), .mem_data_i(wdata_b), .mem_sel_i(sel_b),
    .mem_write_finish(wfin_b), .mem_read_finish(rfin_b),
    .mem_data_o(data_o_b), .mem_stall_o(stall_b), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        flush, en, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        e_req, e_rfin, e_wfin, e_stall;
    logic [31:0] e_dout;
    logic        e_wr;
    logic [3:0]  e_sel;
    logic [31:0] e_addr, e_wdata;
    int          e_infl, e_disc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(string n, logic fl, logic en, logic we, logic [31:0] ad, logic [31:0] wd,
                               logic [3:0] sl, logic aok, logic dok, logic [31:0] rd,
                               logic req, logic rf, logic wf, logic st, logic [31:0] dout,
                               logic ewr, logic [3:0] esl, logic [31:0] ead, logic [31:0] ewd,
                               int infl, int disc);
    vec_t v;
    v.name = n; v.flush = fl; v.en = en; v.we = we; v.addr = ad; v.wdata = wd; v.sel = sl;
    v.addr_ok = aok; v.data_ok = dok; v.rdata = rd;
    v.e_req = req; v.e_rfin = rf; v.e_wfin = wf; v.e_stall = st; v.e_dout = dout;
    v.e_wr = ewr; v.e_sel = esl; v.e_addr = ead; v.e_wdata = ewd; v.e_infl = infl; v.e_disc = disc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    flush_a = v.flush; en_a = v.en; we_a = v.we;
    addr_a = v.addr; wdata_a = v.wdata; sel_a = v.sel;
    bus_a.addr_ok = v.addr_ok; bus_a.data_ok = v.data_ok; bus_a.rdata = v.rdata;
    #1;
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput({v.name, ".req"},      32'(bus_a.req),        32'(v.e_req));
    checkOutput({v.name, ".rfin"},     32'(rfin_a),           32'(v.e_rfin));
    checkOutput({v.name, ".wfin"},     32'(wfin_a),           32'(v.e_wfin));
    checkOutput({v.name, ".stall"},    32'(stall_a),          32'(v.e_stall));
    checkOutput({v.name, ".data_o"},   data_o_a,              v.e_dout);
    checkOutput({v.name, ".wr"},       32'(bus_a.wr),         32'(v.e_wr));
    checkOutput({v.name, ".select"},   32'(bus_a.select),     32'(v.e_sel));
    checkOutput({v.name, ".addr"},     bus_a.addr,            v.e_addr);
    checkOutput({v.name, ".wdata"},    bus_a.wdata,           v.e_wdata);
    checkOutput({v.name, ".inflight"}, 32'(dut_a.inflight),   32'(v.e_infl));
    checkOutput({v.name, ".discard"},  32'(dut_a.discard),    32'(v.e_disc));
  endtask

  task automatic stepB(input logic fl, input logic en, input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    flush_b = fl; en_b = en;
    bus_b.addr_ok = aok; bus_b.data_ok = dok; bus_b.rdata = rd;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush_a = 0; en_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; sel_a = 0;
    bus_a.addr_ok = 0; bus_a.data_ok = 0; bus_a.rdata = 0;
    flush_b = 0; en_b = 0; we_b = 0; addr_b = 32'h600; wdata_b = 0; sel_b = 4'hF;
    bus_b.addr_ok = 0; bus_b.data_ok = 0; bus_b.rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst.req",      32'(bus_a.req),      32'h0);
    checkOutput("rst.addr",     bus_a.addr,          32'h0);
    checkOutput("rst.wdata",    bus_a.wdata,         32'h0);
    checkOutput("rst.select",   32'(bus_a.select),   32'h0);
    checkOutput("rst.rfin",     32'(rfin_a),         32'h0);
    checkOutput("rst.inflight", 32'(dut_a.inflight), 32'h0);

    // name, fl,en,we,addr,wdata,sel,aok,dok,rdata | req,rf,wf,stall,dout | wr,sel,addr,wdata | infl,disc
    tbl.push_back(mkv("rd0",  0,1,0,32'h100,0,4'hF,0,0,0,            0,0,0,1,0,            0,4'h0,32'h0,0,0,0));
    tbl.push_back(mkv("rd1",  0,1,0,32'h100,0,4'hF,1,0,0,            1,0,0,1,0,            0,4'hF,32'h100,0,0,0));
    tbl.push_back(mkv("rd2",  0,1,0,32'h100,0,4'hF,0,1,32'hDEADBEEF, 0,1,0,0,32'hDEADBEEF, 0,4'hF,32'h100,0,1,0));
    tbl.push_back(mkv("rd3",  0,0,0,0,0,4'h0,0,0,0,                  0,0,0,0,0,            0,4'hF,32'h100,0,0,0));
    tbl.push_back(mkv("wr4",  0,1,1,32'h200,32'hCAFEF00D,4'h3,0,0,0, 0,0,0,1,0,            0,4'hF,32'h100,0,0,0));
    tbl.push_back(mkv("wr5",  0,1,1,32'h200,32'hCAFEF00D,4'h3,0,0,0, 1,0,0,1,0,            1,4'h3,32'h200,32'hCAFEF00D,0,0));
    tbl.push_back(mkv("wr6",  0,1,1,32'h200,32'hCAFEF00D,4'h3,0,0,0, 1,0,0,1,0,            1,4'h3,32'h200,32'hCAFEF00D,0,0));
    tbl.push_back(mkv("wr7",  0,1,1,32'h200,32'hCAFEF00D,4'h3,0,0,0, 1,0,0,1,0,            1,4'h3,32'h200,32'hCAFEF00D,0,0));
    tbl.push_back(mkv("wr8",  0,1,1,32'h200,32'hCAFEF00D,4'h3,1,0,0, 1,0,0,1,0,            1,4'h3,32'h200,32'hCAFEF00D,0,0));
    tbl.push_back(mkv("wr9",  0,1,1,32'h200,32'hCAFEF00D,4'h3,0,0,0, 0,0,0,1,0,            1,4'h3,32'h200,32'hCAFEF00D,1,0));
    tbl.push_back(mkv("wr10", 0,1,1,32'h200,32'hCAFEF00D,4'h3,0,1,32'h55, 0,0,1,0,32'h55,  1,4'h3,32'h200,32'hCAFEF00D,1,0));
    tbl.push_back(mkv("wr11", 0,0,0,0,0,4'h0,0,0,0,                  0,0,0,0,0,            1,4'h3,32'h200,32'hCAFEF00D,0,0));
    tbl.push_back(mkv("fr12", 0,1,0,32'h300,0,4'hF,0,0,0,            0,0,0,1,0,            1,4'h3,32'h200,32'hCAFEF00D,0,0));
    tbl.push_back(mkv("fr13", 1,1,0,32'h300,0,4'hF,0,0,0,            1,0,0,1,0,            0,4'hF,32'h300,0,0,0));
    tbl.push_back(mkv("fr14", 0,0,0,0,0,4'h0,0,0,0,                  1,0,0,0,0,            0,4'hF,32'h300,0,0,0));
    tbl.push_back(mkv("fr15", 0,0,0,0,0,4'h0,1,0,0,                  1,0,0,0,0,            0,4'hF,32'h300,0,0,0));
    tbl.push_back(mkv("fr16", 0,0,0,0,0,4'h0,0,0,0,                  0,0,0,0,0,            0,4'hF,32'h300,0,1,1));
    tbl.push_back(mkv("fr17", 0,0,0,0,0,4'h0,0,1,32'hBAD,            0,0,0,0,32'hBAD,      0,4'hF,32'h300,0,1,1));
    tbl.push_back(mkv("fr18", 0,0,0,0,0,4'h0,0,0,0,                  0,0,0,0,0,            0,4'hF,32'h300,0,0,0));
    tbl.push_back(mkv("rf19", 0,1,0,32'h400,0,4'hF,0,0,0,            0,0,0,1,0,            0,4'hF,32'h300,0,0,0));
    tbl.push_back(mkv("rf20", 0,1,0,32'h400,0,4'hF,1,0,0,            1,0,0,1,0,            0,4'hF,32'h400,0,0,0));
    tbl.push_back(mkv("rf21", 1,1,0,32'h400,0,4'hF,0,0,0,            0,0,0,1,0,            0,4'hF,32'h400,0,1,0));
    tbl.push_back(mkv("rf22", 0,1,0,32'h500,0,4'hF,0,0,0,            0,0,0,1,0,            0,4'hF,32'h400,0,1,1));
    tbl.push_back(mkv("rf23", 0,1,0,32'h500,0,4'hF,1,0,0,            1,0,0,1,0,            0,4'hF,32'h500,0,1,1));
    tbl.push_back(mkv("rf24", 0,1,0,32'h500,0,4'hF,0,1,32'hAAAA,     0,0,0,1,32'hAAAA,     0,4'hF,32'h500,0,2,1));
    tbl.push_back(mkv("rf25", 0,1,0,32'h500,0,4'hF,0,1,32'h12345678, 0,1,0,0,32'h12345678, 0,4'hF,32'h500,0,1,0));
    tbl.push_back(mkv("rf26", 0,0,0,0,0,4'h0,0,0,0,                  0,0,0,0,0,            0,4'hF,32'h500,0,0,0));
    tbl.push_back(mkv("fi27", 1,1,0,32'h800,0,4'hF,0,0,0,            0,0,0,1,0,            0,4'hF,32'h500,0,0,0));
    tbl.push_back(mkv("fi28", 0,0,0,0,0,4'h0,0,0,0,                  0,0,0,0,0,            0,4'hF,32'h500,0,0,0));

    $display("[TB] vector table: %0d entries", tbl.size());
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkVector(tbl[i]);
    end

    // Single-slot instance: a flushed transaction blocks the next request until its response drains.
    $display("[TB] MAX_OUTSTANDING=1 sequence");
    stepB(0,1,0,0,0);
    checkOutput("b0.req", 32'(bus_b.req), 32'h0);
    stepB(0,1,1,0,0);
    checkOutput("b1.req", 32'(bus_b.req), 32'h1);
    stepB(1,1,0,0,0);
    checkOutput("b2.req", 32'(bus_b.req), 32'h0);
    checkOutput("b2.rfin", 32'(rfin_b), 32'h0);
    for (int k = 0; k < 3; k++) begin
      stepB(0,1,0,0,0);
      checkOutput($sformatf("b%0d.req", 3 + k), 32'(bus_b.req), 32'h0);
      checkOutput($sformatf("b%0d.discard", 3 + k), 32'(dut_b.discard), 32'h1);
    end
    stepB(0,1,0,1,32'h99);
    checkOutput("b6.req", 32'(bus_b.req), 32'h0);
    checkOutput("b6.rfin", 32'(rfin_b), 32'h0);
    checkOutput("b6.stall", 32'(stall_b), 32'h1);
    stepB(0,1,1,0,0);
    checkOutput("b7.req", 32'(bus_b.req), 32'h1);
    stepB(0,1,0,1,32'h77);
    checkOutput("b8.rfin", 32'(rfin_b), 32'h1);
    checkOutput("b8.data_o", data_o_b, 32'h77);
    stepB(0,0,0,0,0);
    checkOutput("b9.inflight", 32'(dut_b.inflight), 32'h0);

    // Reset while a read is waiting in RESP must clear all tracking.
    $display("[TB] reset mid-transaction");
    applyStimulus(mkv("r0", 0,1,0,32'h700,32'h1234,4'h5,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    applyStimulus(mkv("r1", 0,1,0,32'h700,32'h1234,4'h5,1,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    checkOutput("r1.req", 32'(bus_a.req), 32'h1);
    applyStimulus(mkv("r2", 0,1,0,32'h700,32'h1234,4'h5,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    checkOutput("r2.inflight", 32'(dut_a.inflight), 32'h1);
    checkOutput("r2.addr", bus_a.addr, 32'h700);
    @(negedge clk);
    rst = 1'b1;
    en_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("r4.state",    32'(dut_a.state),    32'h0);
    checkOutput("r4.req",      32'(bus_a.req),      32'h0);
    checkOutput("r4.addr",     bus_a.addr,          32'h0);
    checkOutput("r4.wdata",    bus_a.wdata,         32'h0);
    checkOutput("r4.select",   32'(bus_a.select),   32'h0);
    checkOutput("r4.inflight", 32'(dut_a.inflight), 32'h0);
    checkOutput("r4.discard",  32'(dut_a.discard),  32'h0);
    checkOutput("r4.rfin",     32'(rfin_a),         32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
